// File: rtl/s1_tx_pkg.sv
// Shared constants and state type for the S1 transmitter / S2 receiver pair.
package s1_tx_pkg;

  localparam int unsigned NWORDS    = 18;
  localparam int unsigned NFRAMES   = 8;
  localparam int unsigned AW        = 3;
  localparam int unsigned FRAME_LEN = AW + NWORDS;
  localparam int unsigned DW        = 8;
  localparam int unsigned PW        = 5;
  localparam int unsigned RAW       = 5;

  typedef enum logic {
    SEND = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/s1_tx.sv
// S1 transmitter: transposes RB1 (18x8) into eight gap-free 21-bit serial frames.
// The p register tracks the frame bit currently on sd; each edge prepares the next bit.
module s1_tx
  import s1_tx_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  output logic           RB1_RW,
  output logic [RAW-1:0] RB1_A,
  input  logic [DW-1:0]  RB1_Q,
  output logic           sen,
  output logic           sd,
  output logic           S1_done
);

  state_t          state_q, state_d;
  logic [AW-1:0]   fc_q, fc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [RAW-1:0]  addr_d;
  logic            sd_d, sen_d, done_d;
  logic [AW-1:0]   fc_sh;

  // RB1 is only ever read
  assign RB1_RW = 1'b1;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    p_d     = p_q;
    addr_d  = RB1_A;
    sd_d    = sd;
    sen_d   = sen;
    done_d  = S1_done;
    fc_sh   = '0;
    unique case (state_q)
      SEND: begin
        if (p_q == PW'(FRAME_LEN - 1)) begin
          if (fc_q == AW'(NFRAMES - 1)) begin
            state_d = DONE;
            sen_d   = 1'b0;
            sd_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Wrap into next frame: emit its A[2], rewind the word address
            p_d    = '0;
            fc_d   = fc_q + AW'(1);
            addr_d = '0;
            sd_d   = fc_d[AW-1];
          end
        end else begin
          p_d = p_q + PW'(1);
          if (p_d < PW'(AW)) begin
            // Address bits come from the frame counter, MSB first
            fc_sh = fc_q << p_d;
            sd_d  = fc_sh[AW-1];
          end else begin
            // Data bit: RB1_A already points at word p_d-3; bit plane 7-fc
            sd_d = RB1_Q[~fc_q];
            if (p_d < PW'(FRAME_LEN - 1)) begin
              addr_d = RAW'(p_d - PW'(2));
            end
          end
        end
      end
      DONE: begin
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEND;
      fc_q    <= '0;
      p_q     <= '0;
      RB1_A   <= '0;
      sd      <= 1'b0;
      sen     <= 1'b1;
      S1_done <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      p_q     <= p_d;
      RB1_A   <= addr_d;
      sd      <= sd_d;
      sen     <= sen_d;
      S1_done <= done_d;
    end
  end

endmodule
